// File: rtl/yin_pkg.sv
// Shared types and constants for the divider-sharing logic.
// Holds the arbiter state encoding and the error quotient.
package yin_pkg;

    localparam int DEFAULT_BITS = 64;

    localparam logic [DEFAULT_BITS-1:0] DIV_ERR_RESULT = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request after last_idx,
// wrapping, as a one-hot grant plus its index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  request,
    input  logic [IW-1:0] last_idx,
    input  logic          enable,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    int            j;
    logic [IW-1:0] jj;

    // Scan farthest-first so the closest candidate overwrites the rest.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        j         = 0;
        jj        = '0;
        if (enable) begin
            for (int i = N; i >= 1; i--) begin
                j = int'(last_idx) + i;
                if (j >= N) j = j - N;
                jj = IW'(j);
                if (request[jj]) begin
                    grant     = '0;
                    grant[jj] = 1'b1;
                    grant_idx = jj;
                end
            end
        end
    end

endmodule

// File: rtl/sar_div_arbiter.sv
// Shares one SAR divider among NUM_REQ requesters: round-robin grant,
// start pulse, watchdog, and a one-cycle response to the owner.
module sar_div_arbiter
    import yin_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int BITS    = DEFAULT_BITS,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*BITS-1:0] req_dividendo,
    input  logic [NUM_REQ*BITS-1:0] req_divisor,
    output logic [NUM_REQ-1:0]      resp_valid,
    output logic [BITS-1:0]         resp_result,
    output logic                    resp_error,
    output logic                    busy,
    output logic                    div_reset,
    output logic [BITS-1:0]         div_dividendo,
    output logic [BITS-1:0]         div_divisor,
    input  logic                    div_ready,
    input  logic [BITS-1:0]         div_result
);

    localparam int IW  = $clog2(NUM_REQ);
    localparam int WC  = $clog2(TIMEOUT + 1);
    localparam int WW  = (WC > 8) ? WC : 8;

    arb_state_t     state_q, state_d;
    logic [IW-1:0]  last_q, owner_q;
    logic [BITS-1:0] dvd_q, dvs_q, res_q;
    logic           err_q;
    logic [WW-1:0]  wd_q;

    logic [NUM_REQ-1:0] grant;
    logic [IW-1:0]      grant_idx;
    logic               accept;
    logic [BITS-1:0]    sel_dvd, sel_dvs;
    logic               sel_zero;
    logic               ready_ok;
    logic               wd_hit;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .request   (req_valid),
        .last_idx  (last_q),
        .enable    ((state_q == IDLE) && reset),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign accept   = |grant;
    assign sel_dvd  = req_dividendo[int'(grant_idx)*BITS +: BITS];
    assign sel_dvs  = req_divisor[int'(grant_idx)*BITS +: BITS];
    assign sel_zero = (sel_dvs == '0);

    // A zero watchdog marks the first WAIT cycle, where div_ready is stale.
    assign ready_ok = (wd_q != '0) && div_ready;
    assign wd_hit   = (wd_q == WW'(TIMEOUT));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (accept) state_d = sel_zero ? RESP : START;
            START: state_d = WAIT;
            WAIT:  if (ready_ok || wd_hit) state_d = RESP;
            RESP:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= IW'(NUM_REQ - 1);
            owner_q <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        dvd_q   <= sel_dvd;
                        dvs_q   <= sel_dvs;
                        owner_q <= grant_idx;
                        last_q  <= grant_idx;
                        if (sel_zero) begin
                            res_q <= BITS'(DIV_ERR_RESULT);
                            err_q <= 1'b1;
                        end
                    end
                end
                START: wd_q <= '0;
                WAIT: begin
                    if (ready_ok) begin
                        res_q <= div_result;
                        err_q <= 1'b0;
                    end else if (wd_hit) begin
                        res_q <= '0;
                        err_q <= 1'b1;
                    end else if (wd_q != '1) begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                RESP: ;
            endcase
        end
    end

    always_comb begin
        resp_valid = '0;
        if (state_q == RESP) resp_valid[owner_q] = 1'b1;
    end

    assign req_ready     = grant;
    assign resp_result   = res_q;
    assign resp_error    = err_q;
    assign busy          = (state_q != IDLE);
    assign div_reset     = (state_q == START);
    assign div_dividendo = dvd_q;
    assign div_divisor   = dvs_q;

endmodule

// File: tb/tb_sar_div_arbiter.sv
// Bench for sar_div_arbiter: divider model, per-cycle reference model,
// and directed scenarios with hand-computed expectations.
module tb_sar_div_arbiter;

    localparam int NR = 4;
    localparam int B  = 64;
    localparam int TO = 255;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*B-1:0] req_dvd, req_dvs;
    logic [NR-1:0]   resp_valid;
    logic [B-1:0]    resp_result;
    logic            resp_error;
    logic            busy, div_reset;
    logic [B-1:0]    div_dividendo, div_divisor;
    logic            div_ready;
    logic [B-1:0]    div_result;

    sar_div_arbiter #(.NUM_REQ(NR), .BITS(B), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .reset         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_dividendo (req_dvd),
        .req_divisor   (req_dvs),
        .resp_valid    (resp_valid),
        .resp_result   (resp_result),
        .resp_error    (resp_error),
        .busy          (busy),
        .div_reset     (div_reset),
        .div_dividendo (div_dividendo),
        .div_divisor   (div_divisor),
        .div_ready     (div_ready),
        .div_result    (div_result)
    );

    always #5 clk = ~clk;

    // Divider model: result LAT cycles after the start pulse; ready stays
    // high afterwards and is still high in the first cycle after a restart.
    int         d_lat  = 64;
    bit         d_hang = 1'b0;
    int         d_cnt  = 0;
    logic       d_rdy  = 1'b0;
    logic [B-1:0] d_a = '0, d_b = '0, d_q = '0;

    always @(posedge clk) begin
        if (div_reset) begin
            d_cnt <= 0;
            d_a   <= div_dividendo;
            d_b   <= div_divisor;
        end else begin
            if (d_cnt < 100000) d_cnt <= d_cnt + 1;
            d_rdy <= !d_hang && (d_cnt + 1 >= d_lat);
            if (!d_hang && (d_cnt + 1 >= d_lat) && d_b != 0)
                d_q <= d_a / d_b;
        end
    end

    assign div_ready  = d_rdy;
    assign div_result = d_q;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    function automatic int idx_of(logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Reference model: a transaction is described by its accept cycle;
    // every other output follows from offsets to that cycle.
    bit           m_act = 1'b0;
    bit           m_zero = 1'b0;
    int           m_acc = 0, m_resp = -1, m_own = 0, m_last = NR - 1;
    logic [B-1:0] m_dvd = '0, m_dvs = '0, m_eres = '0;
    bit           m_eerr = 1'b0;
    int           dr_cnt = 0;
    bit           stale_seen = 1'b0;

    int           acc_cyc[$];
    int           rsp_cyc[$];
    int           rsp_own[$];
    logic [B-1:0] rsp_res[$];
    bit           rsp_err[$];

    always @(negedge clk) begin : cmp
        logic [NR-1:0] e_rdy, e_rv;
        int g, k;
        cyc++;
        if (!rst_n) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_div_reset", div_reset, 0);
            chk("rst_div_dividendo", div_dividendo, 0);
            chk("rst_div_divisor", div_divisor, 0);
            chk("rst_resp_result", resp_result, 0);
            chk("rst_resp_error", resp_error, 0);
            m_act  = 1'b0;
            m_last = NR - 1;
            m_dvd  = '0;
            m_dvs  = '0;
        end else begin
            e_rdy = '0;
            e_rv  = '0;
            g     = -1;
            k     = cyc - m_acc;
            if (!m_act) begin
                for (int i = 1; i <= NR; i++) begin
                    int j;
                    j = (m_last + i) % NR;
                    if (g < 0 && req_valid[j]) g = j;
                end
            end
            if (g >= 0) e_rdy[g] = 1'b1;
            if (m_act && cyc == m_resp) e_rv[m_own] = 1'b1;
            chk("req_ready", req_ready, e_rdy);
            chk("resp_valid", resp_valid, e_rv);
            chk("busy", busy, m_act);
            chk("div_reset", div_reset, m_act && !m_zero && k == 1);
            chk("div_dividendo", div_dividendo, m_dvd);
            chk("div_divisor", div_divisor, m_dvs);
            if (e_rv != 0) begin
                chk("resp_result", resp_result, m_eres);
                chk("resp_error", resp_error, m_eerr);
            end
            if (req_ready != 0) acc_cyc.push_back(cyc);
            if (resp_valid != 0) begin
                rsp_cyc.push_back(cyc);
                rsp_own.push_back(idx_of(resp_valid));
                rsp_res.push_back(resp_result);
                rsp_err.push_back(resp_error);
            end
            if (div_reset) dr_cnt++;
            if (m_act && !m_zero && k == 2 && div_ready) stale_seen = 1'b1;
            if (!m_act && g >= 0) begin
                m_act  = 1'b1;
                m_acc  = cyc;
                m_own  = g;
                m_last = g;
                m_dvd  = req_dvd[g*B +: B];
                m_dvs  = req_dvs[g*B +: B];
                m_zero = (m_dvs == 0);
                m_resp = -1;
                if (m_zero) begin
                    m_resp = cyc + 1;
                    m_eres = '1;
                    m_eerr = 1'b1;
                end
            end else if (m_act) begin
                if (cyc == m_resp) begin
                    m_act = 1'b0;
                end else if (m_resp < 0) begin
                    if (k >= 3 && div_ready) begin
                        m_resp = cyc + 1;
                        m_eres = m_dvd / m_dvs;
                        m_eerr = 1'b0;
                    end else if (k == 2 + TO) begin
                        m_resp = cyc + 1;
                        m_eres = '0;
                        m_eerr = 1'b1;
                    end
                end
            end
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic req(int i, logic [B-1:0] a, logic [B-1:0] b);
        int t;
        req_dvd[i*B +: B] = a;
        req_dvs[i*B +: B] = b;
        req_valid[i] = 1'b1;
        t = 0;
        while (t < 600) begin
            @(negedge clk);
            if (req_ready[i]) break;
            t++;
        end
        checks++;
        if (t >= 600) begin
            errors++;
            $display("FAIL accept_wait requester=%0d got=none exp=accept", i);
        end
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_resp(int n, int budget);
        int t;
        t = 0;
        while (rsp_cyc.size() < n && t < budget) begin
            @(posedge clk);
            t++;
        end
        #1;
        checks++;
        if (rsp_cyc.size() < n) begin
            errors++;
            $display("FAIL resp_wait got=%0d exp=%0d", rsp_cyc.size(), n);
        end
    endtask

    int           ai, ri, d0, t;
    int           exp_own[5];
    logic [B-1:0] exp_res[5];

    initial begin
        exp_own = '{0, 1, 2, 3, 0};
        exp_res = '{64'd33, 64'd28, 64'd27, 64'd30, 64'd33};
        req_valid = '0;
        req_dvd   = '0;
        req_dvs   = '0;
        step(3);
        chk("reset_busy", busy, 0);
        chk("reset_resp_result", resp_result, 0);
        rst_n = 1'b1;
        step(2);

        ai = acc_cyc.size(); ri = rsp_cyc.size();
        req(2, 64'd1000, 64'd8);
        wait_resp(ri + 1, 200);
        chk("single_owner", rsp_own[ri], 2);
        chk("single_result", rsp_res[ri], 125);
        chk("single_error", rsp_err[ri], 0);
        chk("single_latency", rsp_cyc[ri] - acc_cyc[ai], 67);
        chk("single_div_reset_pulses", dr_cnt, 1);

        stale_seen = 1'b0;
        ai = acc_cyc.size(); ri = rsp_cyc.size();
        req(3, 64'd81, 64'd9);
        wait_resp(ri + 1, 200);
        chk("stale_ready_present", stale_seen, 1);
        chk("stale_result", rsp_res[ri], 9);
        chk("stale_latency", rsp_cyc[ri] - acc_cyc[ai], 67);

        ri = rsp_cyc.size(); ai = acc_cyc.size();
        req_dvd = {64'd400, 64'd300, 64'd200, 64'd100};
        req_dvs = {64'd13, 64'd11, 64'd7, 64'd3};
        req_valid = '1;
        t = 0;
        while (acc_cyc.size() < ai + 5 && t < 800) begin
            @(posedge clk);
            t++;
        end
        #1;
        req_valid = '0;
        wait_resp(ri + 5, 400);
        for (int i = 0; i < 5; i++) begin
            chk("contend_owner", rsp_own[ri+i], exp_own[i]);
            chk("contend_result", rsp_res[ri+i], exp_res[i]);
        end

        d0 = dr_cnt;
        ai = acc_cyc.size(); ri = rsp_cyc.size();
        req(1, 64'd55, 64'd0);
        wait_resp(ri + 1, 20);
        chk("div0_owner", rsp_own[ri], 1);
        chk("div0_latency", rsp_cyc[ri] - acc_cyc[ai], 1);
        chk("div0_result", rsp_res[ri], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("div0_error", rsp_err[ri], 1);
        step(3);
        chk("div0_no_start", dr_cnt, d0);

        d_hang = 1'b1;
        step(2);
        ai = acc_cyc.size(); ri = rsp_cyc.size();
        req(0, 64'd5, 64'd1);
        wait_resp(ri + 1, 400);
        chk("timeout_latency", rsp_cyc[ri] - acc_cyc[ai], 258);
        chk("timeout_result", rsp_res[ri], 0);
        chk("timeout_error", rsp_err[ri], 1);
        step(2);
        chk("timeout_idle", busy, 0);
        d_hang = 1'b0;

        req(2, 64'd77, 64'd7);
        step(10);
        chk("mid_busy", busy, 1);
        req_dvd[3*B +: B] = 64'd640;
        req_dvs[3*B +: B] = 64'd8;
        req_valid[3] = 1'b1;
        ri = rsp_cyc.size();
        rst_n = 1'b0;
        #1;
        chk("async_busy", busy, 0);
        chk("async_div_reset", div_reset, 0);
        chk("async_req_ready", req_ready, 0);
        chk("async_div_dividendo", div_dividendo, 0);
        step(2);
        rst_n = 1'b1;
        ai = acc_cyc.size();
        req(3, 64'd640, 64'd8);
        wait_resp(ri + 1, 200);
        chk("post_reset_owner", rsp_own[ri], 3);
        chk("post_reset_result", rsp_res[ri], 80);
        chk("post_reset_latency", rsp_cyc[ri] - acc_cyc[ai], 67);
        step(3);
        chk("post_reset_resp_count", rsp_cyc.size(), ri + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sar_div_arbiter.md
# sar_div_arbiter

Shares one `sar_divisor_module` among `NUM_REQ` requesters (modiff average/normalisation stage, threshold/pitch stage, future refinement stages). It grants the divider round-robin, sequences its start pulse and completion, and returns each quotient to its owner with a one-cycle pulse. It handles divide-by-zero and hung divides without invoking or waiting on the divider.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `BITS`, 64, dividend/divisor/quotient width; equals divider `BITS`
- `TIMEOUT`, 255, max `WAIT` cycles before abort (≥ 2·`BITS`)

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low; all state cleared while low
- `req_valid`  in  `NUM_REQ`  request per requester; held with stable operands until accepted
- `req_ready`  out  `NUM_REQ`  one-hot accept pulse
- `req_dividendo`  in  `NUM_REQ*BITS`  flat, requester i at `[i*BITS+:BITS]`
- `req_divisor`  in  `NUM_REQ*BITS`  flat, same packing
- `resp_valid`  out  `NUM_REQ`  one-hot one-cycle completion pulse
- `resp_result`  out  `BITS`  quotient; valid only with `resp_valid`
- `resp_error`  out  1  with `resp_valid`: divide-by-zero or timeout
- `busy`  out  1  high in any state but `IDLE`
- `div_reset`  out  1  divider start pulse, active-high
- `div_dividendo`, `div_divisor`  out  `BITS`  latched operands
- `div_ready`  in  1  divider done
- `div_result`  in  `BITS`  divider quotient

## Operation
- States: `IDLE`, `START`, `WAIT`, `RESP`.
- `IDLE`: if any `req_valid`, pick the first set bit searching from `last+1` upward with wrap; `last` resets to `NUM_REQ-1`, so requester 0 wins first. `req_ready[g]` is combinational, high only in `IDLE`. On that edge, latch operands, owner `g`, and `last<=g`.
  - Divisor ≠ 0: go to `START`.
  - Divisor = 0: load result all-ones and error=1, then go to `RESP`.
- `START`: `div_reset`=1 for exactly one cycle, then go to `WAIT`. Clear the watchdog.
- `WAIT`: `div_reset`=0. Ignore `div_ready` in the first `WAIT` cycle, because it may be stale from the prior divide. After that, `div_ready`=1 latches `div_result` with error=0 and moves to `RESP`. If the watchdog reaches `TIMEOUT`, latch result 0 with error=1 and move to `RESP`.
- `RESP`: `resp_valid[owner]`=1, `resp_result`/`resp_error` driven from registers, then go to `IDLE`.
- Requests are never preempted. A requester that drops `req_valid` before acceptance is simply not served.
- The owner may raise `req_valid` again in the `RESP` cycle. It is arbitrated in the next `IDLE` cycle at lowest priority.
- `div_dividendo`/`div_divisor` hold the last latched operands; they do not change outside acceptance.
- Reset values: all outputs 0, state `IDLE`, watchdog 0, result register 0.
- Asserting `reset` mid-divide aborts it silently: no response, divider output ignored. After release, the next `WAIT` again ignores its first-cycle `div_ready`.

## Timing
- Accept edge at cycle 0.
  - `div_reset` high in cycle 1.
  - `WAIT` from cycle 2.
  - `resp_valid` one cycle after `div_ready` is sampled.
- Total latency: divider latency + 3 cycles.
- Divide-by-zero: `resp_valid` in cycle 1.
- Timeout: `resp_valid` `TIMEOUT`+3 cycles after accept.
- Throughput: at most one accept per `NUM_REQ`-agnostic transaction. `IDLE` lasts ≥1 cycle between transactions.
- Watchdog: 8-bit minimum, sized `$clog2(TIMEOUT+1)`, saturating.

## Structure
- Shared package `yin_pkg`:
  - state enum `arb_state_t` (`IDLE`=0, `START`=1, `WAIT`=2, `RESP`=3)
  - `DIV_ERR_RESULT` (all-ones) constant
  - default `BITS`
- Sub-module `rr_arbiter`:
  - parameter `N`; inputs `request[N]`, `last_idx`, `enable`
  - outputs one-hot `grant[N]` and `grant_idx`; purely combinational
- The FSM, operand/result registers and watchdog stay in `sar_div_arbiter`.

## Test plan
- Single request: requester 2 with 1000/8, divider model latency 64 → `req_ready[2]` at accept, one `div_reset` pulse, `resp_valid[2]` with result 125 and error 0 exactly 67 cycles after accept.
- Contention: all four requesters valid continuously with distinct operands (100/3, 200/7, 300/11, 400/13) → served in order 0,1,2,3,0 with results 33, 28, 27, 30; no requester starved.
- Divide-by-zero: requester 1 with 55/0 → `resp_valid[1]` one cycle after accept, result 0xFFFF_FFFF_FFFF_FFFF, `resp_error`=1, `div_reset` never asserted.
- Stale ready: `div_ready` held high from the previous divide during `START` and the first `WAIT` cycle → not accepted; response uses the new `div_result` (e.g. 81/9 → 9).
- Timeout: divider model never raises `div_ready`, `TIMEOUT`=255 → `resp_valid` 258 cycles after accept with result 0 and error 1, then `IDLE`.
- Reset mid-divide: `reset` low in `WAIT` → all outputs 0 immediately (asynchronous), no `resp_valid` for that owner. After release, a new request completes normally.
